// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types, bubble constants and occupancy encoding
package pipe_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) used to fill empty instruction slots.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // IF/ID payload as packed by the fetch stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        pred_taken;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    // Bubble for an empty IF/ID stage: everything zero except a NOP in the instruction slot.
    localparam if_id_t PIPE_BUBBLE_IF_ID = '{
        pc:         32'h0,
        pc_plus4:   32'h0,
        instr:      RV_NOP,
        pred_taken: 1'b0
    };

    // Encoded so that the state value equals the number of held entries.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-low reset (value -> 0)
//   inc    count one event this cycle
//   clr    synchronous clear, wins over inc
//   value  current count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - pipeline-stage register with valid/ready handshake, flush and optional skid entry
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous kill of all held entries (blocks accepts in the same cycle)
//   in_valid   upstream payload valid
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  downstream payload valid
//   out_ready  downstream accepts this cycle
//   out_data   downstream payload, BUBBLE_VAL when out_valid is low
//   occ        entries held (0..2)
//   cnt_clr    synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 72,
    parameter int                SKID       = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid;
    logic              s_valid;
    logic [DATA_W-1:0] m_data;
    logic              accept;
    logic              release_m;

    assign accept    = in_valid && in_ready;
    assign release_m = m_valid && out_ready;

    generate
        if (SKID == 0) begin : g_single
            // in_ready looks through to out_ready so a full stage can refill in the cycle it drains.
            assign s_valid  = 1'b0;
            assign in_ready = !flush && (!m_valid || out_ready);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_valid <= 1'b0;
                    m_data  <= BUBBLE_VAL;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_data  <= BUBBLE_VAL;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else if (release_m) begin
                    m_valid <= 1'b0;
                    m_data  <= BUBBLE_VAL;
                end
            end
        end else begin : g_skid
            occ_state_e        state_q;
            occ_state_e        state_d;
            logic [DATA_W-1:0] m_data_d;
            logic [DATA_W-1:0] s_data;
            logic [DATA_W-1:0] s_data_d;

            // in_ready depends only on the registered skid flag (and flush), never on out_ready.
            assign m_valid  = (state_q != OCC_EMPTY);
            assign s_valid  = (state_q == OCC_FULL);
            assign in_ready = !flush && !s_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= OCC_EMPTY;
                    m_data  <= BUBBLE_VAL;
                    s_data  <= BUBBLE_VAL;
                end else begin
                    state_q <= state_d;
                    m_data  <= m_data_d;
                    s_data  <= s_data_d;
                end
            end

            always_comb begin
                state_d  = state_q;
                m_data_d = m_data;
                s_data_d = s_data;
                if (flush) begin
                    state_d  = OCC_EMPTY;
                    m_data_d = BUBBLE_VAL;
                    s_data_d = BUBBLE_VAL;
                end else begin
                    case (state_q)
                        OCC_EMPTY: begin
                            if (accept) begin
                                state_d  = OCC_ONE;
                                m_data_d = in_data;
                            end
                        end
                        OCC_ONE: begin
                            if (accept && release_m) begin
                                m_data_d = in_data;
                            end else if (accept) begin
                                state_d  = OCC_FULL;
                                s_data_d = in_data;
                            end else if (release_m) begin
                                state_d  = OCC_EMPTY;
                                m_data_d = BUBBLE_VAL;
                            end
                        end
                        OCC_FULL: begin
                            // The skid entry moves up; in_ready is low so nothing new arrives.
                            if (release_m) begin
                                state_d  = OCC_ONE;
                                m_data_d = s_data;
                                s_data_d = BUBBLE_VAL;
                            end
                        end
                        default: begin
                            state_d  = OCC_EMPTY;
                            m_data_d = BUBBLE_VAL;
                            s_data_d = BUBBLE_VAL;
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occ       = {1'b0, m_valid} + {1'b0, s_valid};

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (m_valid && !out_ready),
        .clr  (cnt_clr),
        .value(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - self-checking bench for pipe_stage_hs (skid and single-entry builds)
module tb_pipe_stage_hs;

    localparam logic [15:0] BUB1 = 16'h0013;
    localparam logic [15:0] BUB0 = 16'hBEEF;

    logic clk;
    logic rst;

    logic        fl1, iv1, ir1, ov1, or1, clr1;
    logic [15:0] id1, od1;
    logic [1:0]  occ1;
    logic [3:0]  sc1;

    logic        fl0, iv0, ir0, ov0, or0, clr0;
    logic [15:0] id0, od0;
    logic [1:0]  occ0;
    logic [15:0] sc0;

    int total = 0;
    int bad   = 0;

    logic [15:0] q1[$];
    logic [15:0] q0[$];
    int cnt1 = 0;
    int cnt0 = 0;

    pipe_stage_hs #(.DATA_W(16), .SKID(1), .BUBBLE_VAL(BUB1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occ(occ1), .cnt_clr(clr1), .stall_cnt(sc1)
    );

    pipe_stage_hs #(.DATA_W(16), .SKID(0), .BUBBLE_VAL(BUB0), .CNT_W(16)) u_single (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .occ(occ0), .cnt_clr(clr0), .stall_cnt(sc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs seen as a FIFO of capacity 2 (skid) or 1 (single).
    function automatic logic [15:0] e_od1();
        return (q1.size() > 0) ? q1[0] : BUB1;
    endfunction
    function automatic logic [15:0] e_od0();
        return (q0.size() > 0) ? q0[0] : BUB0;
    endfunction
    function automatic logic e_ir1();
        return !fl1 && (q1.size() < 2);
    endfunction
    function automatic logic e_ir0();
        return !fl0 && ((q0.size() == 0) || or0);
    endfunction

    task automatic put1(input logic v, input logic [15:0] d, input logic r, input logic f, input logic c);
        iv1 = v; id1 = d; or1 = r; fl1 = f; clr1 = c;
    endtask

    task automatic put0(input logic v, input logic [15:0] d, input logic r, input logic f, input logic c);
        iv0 = v; id0 = d; or0 = r; fl0 = f; clr0 = c;
    endtask

    // Advance one clock: update both models from the inputs held across the edge, return at negedge.
    task automatic tick();
        logic acc, rel;
        @(posedge clk);
        acc = iv1 && e_ir1();
        rel = (q1.size() > 0) && or1;
        if (clr1) cnt1 = 0;
        else if ((q1.size() > 0) && !or1 && cnt1 < 15) cnt1++;
        if (fl1) q1.delete();
        else begin
            if (rel) void'(q1.pop_front());
            if (acc) q1.push_back(id1);
        end
        acc = iv0 && e_ir0();
        rel = (q0.size() > 0) && or0;
        if (clr0) cnt0 = 0;
        else if ((q0.size() > 0) && !or0 && cnt0 < 65535) cnt0++;
        if (fl0) q0.delete();
        else begin
            if (rel) void'(q0.pop_front());
            if (acc) q0.push_back(id0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        put1(1, 16'd40, 0, 0, 0); put0(1, 16'd41, 0, 0, 0);
        tick(); tick();
        put1(1, 16'd5, 0, 0, 0); put0(1, 16'd5, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst_ov1 got=%b want=0", ov1); end
        total++; if (od1 !== BUB1) begin bad++; $display("FAIL rst_od1 got=%h want=%h", od1, BUB1); end
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL rst_ir1 got=%b want=1", ir1); end
        total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL rst_occ1 got=%0d want=0", occ1); end
        total++; if (sc1 !== 4'd0) begin bad++; $display("FAIL rst_sc1 got=%0d want=0", sc1); end
        total++; if (ov0 !== 1'b0 || od0 !== BUB0 || ir0 !== 1'b1)
            begin bad++; $display("FAIL rst_single got=%b/%h/%b want=0/%h/1", ov0, od0, ir0, BUB0); end
        @(posedge clk); #1;
        total++; if (ov1 !== 1'b0 || occ1 !== 2'd0)
            begin bad++; $display("FAIL rst_hold got=%b/%0d want=0/0", ov1, occ1); end
        @(negedge clk);
        rst = 1'b1;
        q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
        put1(0, 0, 0, 0, 0); put0(0, 0, 0, 0, 0);
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 4; i++) begin
            put1(i <= 3, 16'(i), 1, 0, 0);
            #1;
            if (i > 1) begin
                total++; if (ov1 !== 1'b1 || od1 !== 16'(i - 1))
                    begin bad++; $display("FAIL stream_out got=%b/%0d want=1/%0d", ov1, od1, i - 1); end
                total++; if (occ1 !== 2'd1) begin bad++; $display("FAIL stream_occ got=%0d want=1", occ1); end
            end
            total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL stream_ir got=%b want=1", ir1); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        put1(1, 16'd10, 0, 0, 1); #1; tick();
        put1(1, 16'd11, 0, 0, 0); #1;
        total++; if (od1 !== 16'd10 || occ1 !== 2'd1 || ir1 !== 1'b1)
            begin bad++; $display("FAIL bp_first got=%0d/%0d/%b want=10/1/1", od1, occ1, ir1); end
        tick();
        put1(0, 0, 0, 0, 0); #1;
        total++; if (occ1 !== 2'd2 || ir1 !== 1'b0)
            begin bad++; $display("FAIL bp_full got=%0d/%b want=2/0", occ1, ir1); end
        tick();
        put1(0, 0, 1, 0, 0); #1;
        total++; if (od1 !== 16'd10 || occ1 !== 2'd2)
            begin bad++; $display("FAIL bp_rel10 got=%0d/%0d want=10/2", od1, occ1); end
        tick();
        put1(0, 0, 1, 0, 0); #1;
        total++; if (od1 !== 16'd11 || occ1 !== 2'd1 || ir1 !== 1'b1)
            begin bad++; $display("FAIL bp_rel11 got=%0d/%0d/%b want=11/1/1", od1, occ1, ir1); end
        tick();
        put1(0, 0, 1, 0, 0); #1;
        total++; if (occ1 !== 2'd0 || ov1 !== 1'b0)
            begin bad++; $display("FAIL bp_empty got=%0d/%b want=0/0", occ1, ov1); end
        total++; if (sc1 !== 4'd2) begin bad++; $display("FAIL bp_stall got=%0d want=2", sc1); end
    endtask

    task automatic test_flush();
        put1(1, 16'd20, 0, 0, 0); tick();
        put1(1, 16'd21, 0, 0, 0); tick();
        put1(1, 16'd7, 0, 1, 0); #1;
        total++; if (ir1 !== 1'b0 || occ1 !== 2'd2)
            begin bad++; $display("FAIL flush_cycle got=%b/%0d want=0/2", ir1, occ1); end
        tick();
        put1(0, 0, 1, 0, 0); #1;
        total++; if (occ1 !== 2'd0 || ov1 !== 1'b0 || od1 !== BUB1)
            begin bad++; $display("FAIL flush_after got=%0d/%b/%h want=0/0/%h", occ1, ov1, od1, BUB1); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b/%0d want=0", ov1, od1); end
        end
    endtask

    task automatic test_single();
        put0(1, 16'd4, 0, 0, 0); #1; tick();
        put0(1, 16'd9, 0, 0, 0); #1;
        total++; if (ir0 !== 1'b0 || od0 !== 16'd4)
            begin bad++; $display("FAIL single_stall got=%b/%0d want=0/4", ir0, od0); end
        tick();
        put0(1, 16'd9, 1, 0, 0); #1;
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL single_ir got=%b want=1", ir0); end
        tick();
        put0(0, 0, 1, 0, 0); #1;
        total++; if (ov0 !== 1'b1 || od0 !== 16'd9)
            begin bad++; $display("FAIL single_new got=%b/%0d want=1/9", ov0, od0); end
        tick();
        put0(0, 0, 0, 0, 0); #1;
        total++; if (ov0 !== 1'b0 || od0 !== BUB0)
            begin bad++; $display("FAIL single_empty got=%b/%h want=0/%h", ov0, od0, BUB0); end
    endtask

    task automatic test_saturation();
        put1(1, 16'd30, 0, 0, 1); #1; tick();
        repeat (20) begin put1(0, 0, 0, 0, 0); tick(); end
        put1(0, 0, 0, 0, 1); #1;
        total++; if (sc1 !== 4'd15) begin bad++; $display("FAIL sat_max got=%0d want=15", sc1); end
        tick();
        put1(0, 0, 0, 0, 0); #1;
        total++; if (sc1 !== 4'd0) begin bad++; $display("FAIL sat_clr got=%0d want=0", sc1); end
        tick(); #1;
        total++; if (sc1 !== 4'd1) begin bad++; $display("FAIL sat_restart got=%0d want=1", sc1); end
        put1(0, 0, 0, 1, 0); tick();
        put1(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            put1($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
            put0($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
            #1;
            total++; if (ov1 !== (q1.size() > 0) || od1 !== e_od1())
                begin bad++; $display("FAIL rnd_out1 n=%0d got=%b/%h want=%b/%h", n, ov1, od1, q1.size() > 0, e_od1()); end
            total++; if (ir1 !== e_ir1() || occ1 !== 2'(q1.size()))
                begin bad++; $display("FAIL rnd_ctl1 n=%0d got=%b/%0d want=%b/%0d", n, ir1, occ1, e_ir1(), q1.size()); end
            total++; if (sc1 !== 4'(cnt1))
                begin bad++; $display("FAIL rnd_sc1 n=%0d got=%0d want=%0d", n, sc1, cnt1); end
            total++; if (ov0 !== (q0.size() > 0) || od0 !== e_od0())
                begin bad++; $display("FAIL rnd_out0 n=%0d got=%b/%h want=%b/%h", n, ov0, od0, q0.size() > 0, e_od0()); end
            total++; if (ir0 !== e_ir0() || occ0 !== 2'(q0.size()))
                begin bad++; $display("FAIL rnd_ctl0 n=%0d got=%b/%0d want=%b/%0d", n, ir0, occ0, e_ir0(), q0.size()); end
            total++; if (sc0 !== 16'(cnt0))
                begin bad++; $display("FAIL rnd_sc0 n=%0d got=%0d want=%0d", n, sc0, cnt0); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        put1(0, 0, 0, 0, 0);
        put0(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_single();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
